// File: rtl/fpadd_seq.sv
// rtl/fpadd_seq.sv - multi-cycle floating-point adder/subtractor
// Round-to-nearest-even, subnormal inputs flushed to zero, fixed 4-edge latency.
module fpadd_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] s,
  output logic [3:0]           flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
  localparam int EW = EXP_W + 8;   // signed exponent with headroom for left shifts
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic signed [EW-1:0] EMAXS = EW'(EMAX);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic [W-1:0]            a_r, b_r;
  logic                    op_r;
  logic [SW-1:0]           big_r, al_r;
  logic [EXP_W-1:0]        exp_r;
  logic                    sign_r, sub_r, spec_r;
  logic [W-1:0]            spec_s_r;
  logic [3:0]              spec_f_r;
  logic [SW:0]             sum_r;
  logic [SW-1:0]           n_r;
  logic signed [EW-1:0]    e_r;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ALIGN;
      end
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand decode, special detection, magnitude swap and alignment shift
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, d;
  logic [MAN_W-1:0] fa, fb;
  logic             sa, sb, eff_sub, nan_a, nan_b, inf_a, inf_b, a_ge, s_big, lost;
  logic [SW-1:0]    sig_a, sig_b, sig_big, sig_sml, sig_al;
  logic             spec;
  logic [W-1:0]     spec_s;
  logic [3:0]       spec_f;

  always_comb begin
    sa      = a_r[W-1];
    ea      = a_r[W-2:MAN_W];
    fa      = a_r[MAN_W-1:0];
    sb      = b_r[W-1] ^ op_r;
    eb      = b_r[W-2:MAN_W];
    fb      = b_r[MAN_W-1:0];
    eff_sub = sa ^ sb;
    nan_a   = (ea == EMAX) && (fa != '0);
    nan_b   = (eb == EMAX) && (fb != '0);
    inf_a   = (ea == EMAX) && (fa == '0);
    inf_b   = (eb == EMAX) && (fb == '0);
    sig_a   = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
    sig_b   = (eb == '0) ? '0 : {1'b1, fb, 3'b000};
    a_ge    = (ea == '0) ? (eb == '0) : ((eb == '0) || ({ea, fa} >= {eb, fb}));
    sig_big = a_ge ? sig_a : sig_b;
    sig_sml = a_ge ? sig_b : sig_a;
    e_big   = a_ge ? ea : eb;
    e_sml   = a_ge ? eb : ea;
    s_big   = a_ge ? sa : sb;
    d       = e_big - e_sml;
    lost    = 1'b0;
    for (int i = 0; i < SW; i++)
      if (i < int'(d)) lost = lost | sig_sml[i];
    if (int'(d) >= MAN_W + 3) sig_al = {{(SW-1){1'b0}}, |sig_sml};
    else                      sig_al = (sig_sml >> d) | {{(SW-1){1'b0}}, lost};
    spec   = 1'b0;
    spec_s = '0;
    spec_f = 4'b0000;
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
      spec   = 1'b1;
      spec_s = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
      spec_f = 4'b1000;
    end else if (inf_a) begin
      spec   = 1'b1;
      spec_s = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      spec   = 1'b1;
      spec_s = {sb, EMAX, {MAN_W{1'b0}}};
    end
  end

  // Normalisation: carry shifts right, otherwise one-cycle leading-zero count
  logic [6:0]           lzc;
  logic [SW-1:0]        n_nx;
  logic signed [EW-1:0] e_ext, e_nx;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < SW; i++)
      if (sum_r[i]) lzc = 7'(SW - 1 - i);
    e_ext = EW'(exp_r);
    if (sum_r[SW]) begin
      n_nx = {sum_r[SW:2], |sum_r[1:0]};
      e_nx = e_ext + EW'(1);
    end else begin
      n_nx = sum_r[SW-1:0] << lzc;
      e_nx = e_ext - EW'(lzc);
    end
  end

  logic                 up, inx;
  logic [MAN_W+1:0]     mant;
  logic signed [EW-1:0] e_rnd;
  logic [W-1:0]         s_nx;
  logic [3:0]           f_nx;

  always_comb begin
    inx   = |n_r[2:0];
    up    = n_r[2] & (n_r[1] | n_r[0] | n_r[3]);
    mant  = {1'b0, n_r[SW-1:3]} + (MAN_W+2)'(up);
    e_rnd = mant[MAN_W+1] ? e_r + EW'(1) : e_r;
    s_nx  = {sign_r, e_rnd[EXP_W-1:0], mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0]};
    f_nx  = {3'b000, inx};
    if (spec_r) begin
      s_nx = spec_s_r;
      f_nx = spec_f_r;
    end else if (n_r == '0) begin
      // exact cancellation gives +0; only like-signed zeros keep their sign
      s_nx = {sign_r & ~sub_r, {(W-1){1'b0}}};
      f_nx = 4'b0000;
    end else if (e_r <= 0) begin
      s_nx = {sign_r, {(W-1){1'b0}}};
      f_nx = 4'b0011;
    end else if (e_rnd >= EMAXS) begin
      s_nx = {sign_r, EMAX, {MAN_W{1'b0}}};
      f_nx = 4'b0101;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s        <= '0;
      flags    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 1'b0;
      big_r    <= '0;
      al_r     <= '0;
      exp_r    <= '0;
      sign_r   <= 1'b0;
      sub_r    <= 1'b0;
      spec_r   <= 1'b0;
      spec_s_r <= '0;
      spec_f_r <= '0;
      sum_r    <= '0;
      n_r      <= '0;
      e_r      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r  <= a;
          b_r  <= b;
          op_r <= op;
        end
        ALIGN: begin
          big_r    <= sig_big;
          al_r     <= sig_al;
          exp_r    <= e_big;
          sign_r   <= s_big;
          sub_r    <= eff_sub;
          spec_r   <= spec;
          spec_s_r <= spec_s;
          spec_f_r <= spec_f;
        end
        ADD: sum_r <= sub_r ? ({1'b0, big_r} - {1'b0, al_r}) : ({1'b0, big_r} + {1'b0, al_r});
        NORM: begin
          n_r <= n_nx;
          e_r <= e_nx;
        end
        ROUND: begin
          s     <= s_nx;
          flags <= f_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpadd_seq.sv
// tb/tb_fpadd_seq.sv - bench for fpadd_seq (binary32 configuration)
// Reference model rounds the exact wide-integer sum of the operands.
module tb_fpadd_seq;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic [3:0]  flags;
  int          checks = 0;
  int          failures = 0;

  fpadd_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .s(s), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Exact value in units of 2^-149: integer significand shifted by (exp-1)
  function automatic void ref_add(input logic [31:0] x, input logic [31:0] y, input logic o,
                                  output logic [31:0] rs, output logic [3:0] rf);
    logic [7:0]   ex, ey;
    logic [22:0]  fx, fy;
    logic         sx, sy, sg, rup;
    logic [319:0] mx, my, m, mant, rem, half;
    int           p, e, sh;
    sx = x[31]; ex = x[30:23]; fx = x[22:0];
    sy = y[31] ^ o; ey = y[30:23]; fy = y[22:0];
    rs = 32'd0; rf = 4'b0000;
    if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0) || (ex == 8'hFF && ey == 8'hFF && sx != sy)) begin
      rs = 32'h7FC00000; rf = 4'b1000;
    end else if (ex == 8'hFF) begin
      rs = {sx, 8'hFF, 23'd0};
    end else if (ey == 8'hFF) begin
      rs = {sy, 8'hFF, 23'd0};
    end else begin
      mx = (ex == 0) ? 320'd0 : (320'({1'b1, fx}) << (ex - 1));
      my = (ey == 0) ? 320'd0 : (320'({1'b1, fy}) << (ey - 1));
      if (sx == sy)      begin m = mx + my; sg = sx; end
      else if (mx >= my) begin m = mx - my; sg = sx; end
      else               begin m = my - mx; sg = sy; end
      if (m == 0) begin
        rs = {(sx == sy) ? sx : 1'b0, 31'd0};
      end else begin
        p = 0;
        for (int i = 0; i < 320; i++) if (m[i]) p = i;
        e = p - 22;
        if (e <= 0) begin
          rs = {sg, 31'd0}; rf = 4'b0011;
        end else begin
          sh   = p - 23;
          mant = m >> sh;
          rem  = m - (mant << sh);
          rup  = 1'b0;
          if (sh > 0) begin
            half = 320'd1 << (sh - 1);
            rup  = (rem > half) || (rem == half && mant[0]);
          end
          mant = mant + 320'(rup);
          if (mant[24]) begin mant = mant >> 1; e++; end
          if (e >= 255) begin
            rs = {sg, 8'hFF, 23'd0}; rf = 4'b0101;
          end else begin
            rs = {sg, 8'(e), mant[22:0]}; rf = {3'b000, rem != 0};
          end
        end
      end
    end
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                       input logic [31:0] es, input logic [3:0] ef, input string tag);
    int lat, busy;
    a = ta; b = tbv; op = top; in_valid = 1'b1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy = 0;
    while (!out_valid && lat < 16) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    if (!in_ready) busy++;
    chk({tag, ".lat"}, 32'(lat), 32'd4);
    chk({tag, ".s"}, s, es);
    chk({tag, ".flags"}, 32'(flags), 32'(ef));
    @(posedge clk); #1;
    chk({tag, ".busy"}, 32'(busy), 32'd5);
    chk({tag, ".idle"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    logic [31:0] ra, rb, es;
    logic [3:0]  ef;
    logic        rop;
    int          lat, seen, ea_i, eb_i;
    reset = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rdy", 32'(in_ready), 32'd1);
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.s", s, 32'd0);
    chk("reset.flags", 32'(flags), 32'd0);
    reset = 1'b0;

    do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, "one_plus_one");
    do_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "one_minus_one");
    do_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even");
    do_op(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, "inf_minus_inf");
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow");
    do_op(32'h00800000, 32'h80000001, 1'b0, 32'h00800000, 4'b0000, "flush_sub");
    do_op(32'h00C00000, 32'h80800000, 1'b0, 32'h00000000, 4'b0011, "underflow");
    do_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "negz_negz");
    do_op(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, "posz_negz");
    do_op(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, "nan_in");
    do_op(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, "inf_pass");

    // Result held while the consumer stalls; new requests ignored
    out_ready = 1'b0;
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 16) begin @(posedge clk); #1; lat++; end
    chk("hold.lat", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold.valid", 32'(out_valid), 32'd1);
      chk("hold.s", s, 32'h40000000);
      chk("hold.flags", 32'(flags), 32'd0);
      chk("hold.rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release.rdy", 32'(in_ready), 32'd1);
    chk("release.valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    // Reset while the operation sits in NORM
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.s", s, 32'd0);
    chk("midrst.rdy", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("midrst.quiet", 32'(seen), 32'd0);
    do_op(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, "after_rst");

    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 0)      ea_i = int'($urandom_range(1, 4));
      else if (n % 5 == 1) ea_i = int'($urandom_range(250, 254));
      else                 ea_i = int'($urandom_range(1, 254));
      eb_i = ea_i + int'($urandom_range(0, 60)) - 30;
      if (eb_i < 1) eb_i = 1;
      if (eb_i > 254) eb_i = 254;
      ra  = {1'($urandom), 8'(ea_i), 23'($urandom)};
      rb  = {1'($urandom), 8'(eb_i), 23'($urandom)};
      if (n % 4 == 3) rb = {$urandom_range(0, 1) == 1 ? ~ra[31] : ra[31], ra[30:0] ^ 31'($urandom_range(1, 63))};
      rop = 1'($urandom);
      ref_add(ra, rb, rop, es, ef);
      do_op(ra, rb, rop, es, ef, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
